uart_rx_autobaud: RTL and testbench

//   Auto-baud controller for the UART receive path: on request, measures an incoming 0x55 sync

---
 rtl/uart_rx_autobaud.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_autobaud.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_autobaud.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_autobaud
// Description : Auto-baud controller. It times a 0x55 sync character on rx,
//               derives the receiver baud divisor, and holds the receiver off
//               while it measures. Optional build macro UART_AUTOBAUD_CHECK_EN
//               adds a per-bit interval tolerance check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_autobaud #(
    parameter int DIV_SIZE    = 16,
    parameter int DEFAULT_DIV = 434,
    parameter int MIN_DIV     = 16,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic                start_i,
    input  logic                rx_i,
    output logic                rx_en_o,
    output logic [DIV_SIZE-1:0] baud_div_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int CNT_W  = DIV_SIZE + 3;
    localparam int CALC_W = DIV_SIZE + 4;
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] c_TMO_LAST = (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit c_TMO_EN = (TIMEOUT_CYC != 0);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_WAIT = 3'd1;
    localparam logic [2:0] c_MEAS = 3'd2;
    localparam logic [2:0] c_CALC = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;
    localparam logic [2:0] c_FAIL = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [2:0]          r_sync;
    logic                r_rs_d;
    logic                w_rs;
    logic                w_fall;
    logic [TMO_W-1:0]    r_tmo;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_edges;
    logic [CALC_W-1:0]   w_sum;
    logic [CALC_W-1:0]   w_div;
    logic                w_div_bad;
    logic                w_chk_fail;
    logic                r_rx_en;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DIV_SIZE-1:0] r_baud_div;

    // rx is asynchronous; only the third flop output is ever looked at
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= 3'b111;
            r_rs_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[1:0], rx_i};
            r_rs_d <= r_sync[2];
        end
    end

    assign w_rs   = r_sync[2];
    assign w_fall = r_rs_d & ~w_rs;

    // Rounded divide by 8 with one spare bit so the +4 cannot wrap
    assign w_sum     = CALC_W'(r_cnt) + CALC_W'(4);
    assign w_div     = w_sum >> 3;
    assign w_div_bad = (|w_div[CALC_W-1:DIV_SIZE]) || (w_div < CALC_W'(MIN_DIV));

`ifdef UART_AUTOBAUD_CHECK_EN
    logic             w_rise;
    logic             w_edge;
    logic [CNT_W-1:0] r_last;
    logic [CNT_W-1:0] r_ref;
    logic             r_have_ref;
    logic [CNT_W-1:0] w_ivl;
    logic [CNT_W-1:0] w_diff;

    assign w_rise     = ~r_rs_d & w_rs;
    assign w_edge     = w_rise | w_fall;
    assign w_ivl      = r_cnt - r_last;
    assign w_diff     = (w_ivl > r_ref) ? (w_ivl - r_ref) : (r_ref - w_ivl);
    assign w_chk_fail = w_edge & r_have_ref & (w_diff > (r_ref >> 2));

    // The start-bit width becomes the reference every later bit is held against
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last     <= '0;
            r_ref      <= '0;
            r_have_ref <= 1'b0;
        end else if (r_state == c_WAIT) begin
            r_last     <= '0;
            r_have_ref <= 1'b0;
        end else if ((r_state == c_MEAS) && w_edge) begin
            r_last <= r_cnt;
            if (!r_have_ref) begin
                r_ref      <= w_ivl;
                r_have_ref <= 1'b1;
            end
        end
    end
`else
    assign w_chk_fail = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (start_i && en_i) w_next = c_WAIT;
            c_WAIT: begin
                if (!en_i)                                   w_next = c_IDLE;
                else if (w_fall)                             w_next = c_MEAS;
                else if (c_TMO_EN && (r_tmo == c_TMO_LAST))  w_next = c_FAIL;
            end
            c_MEAS: begin
                if (!en_i)                                   w_next = c_IDLE;
                else if (w_chk_fail)                         w_next = c_FAIL;
                else if (w_fall && (r_edges == 2'd3))        w_next = c_CALC;
                else if (&r_cnt)                             w_next = c_FAIL;
            end
            c_CALC: begin
                if (!en_i)          w_next = c_IDLE;
                else if (w_div_bad) w_next = c_FAIL;
                else                w_next = c_DONE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= c_IDLE;
            r_tmo      <= '0;
            r_cnt      <= '0;
            r_edges    <= '0;
            r_rx_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_baud_div <= DIV_SIZE'(DEFAULT_DIV);
        end else begin
            r_state <= w_next;
            r_rx_en <= en_i & (r_state == c_IDLE);
            r_busy  <= (w_next == c_WAIT) | (w_next == c_MEAS) | (w_next == c_CALC);
            r_done  <= (w_next == c_DONE);
            r_err   <= (w_next == c_FAIL);
            case (r_state)
                c_IDLE: begin
                    r_tmo   <= '0;
                    r_cnt   <= '0;
                    r_edges <= '0;
                end
                c_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (w_fall) begin
                        r_cnt   <= CNT_W'(1);
                        r_edges <= '0;
                    end
                end
                c_MEAS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_fall) r_edges <= r_edges + 2'd1;
                end
                c_CALC: if (w_next == c_DONE) r_baud_div <= w_div[DIV_SIZE-1:0];
                default: ;
            endcase
        end
    end

    assign rx_en_o    = r_rx_en;
    assign baud_div_o = r_baud_div;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_autobaud.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_autobaud
// Description : Directed self-checking bench for uart_rx_autobaud.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_autobaud;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        start;
    logic        rx;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;
    int ev_cyc = -1;
    int t0     = 0;

    uart_rx_autobaud #(
        .DIV_SIZE    (16),
        .DEFAULT_DIV (434),
        .MIN_DIV     (16),
        .TIMEOUT_CYC (1000)
    ) u_dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .en_i       (en),
        .start_i    (start),
        .rx_i       (rx),
        .rx_en_o    (rx_en),
        .baud_div_o (baud_div),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) n_done++;
        if (err) n_err++;
        if (done && err) n_both++;
        if (done || err) ev_cyc = cyc;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_done = 0;
        n_err  = 0;
        ev_cyc = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int t);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            tick(t);
        end
    endtask

    // One calibration attempt with a 0x55 sync byte at t clocks per bit
    task automatic calibrate(input string tag, input int t, input int exp_done,
                             input int exp_err, input int exp_div);
        clear_counts();
        pulse_start();
        check({tag, "_busy_on"}, int'(busy), 1);
        send_byte(8'h55, t);
        tick(4);
        check({tag, "_done"}, n_done, exp_done);
        check({tag, "_err"}, n_err, exp_err);
        check({tag, "_latency"}, ev_cyc - t0, 8 * t + 5);
        check({tag, "_div"}, int'(baud_div), exp_div);
        check({tag, "_busy_off"}, int'(busy), 0);
        check({tag, "_rx_en"}, int'(rx_en), 1);
    endtask

    initial begin
        rstn  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        rx    = 1'b1;
        tick(3);
        check("rst_div", int'(baud_div), 434);
        check("rst_rx_en", int'(rx_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rstn = 1'b1;
        tick(2);
        check("idle_no_en", int'(rx_en), 0);

        // start is ignored while the UART is disabled
        pulse_start();
        tick(1);
        check("start_no_en_busy", int'(busy), 0);

        en = 1'b1;
        tick(2);
        check("idle_rx_en", int'(rx_en), 1);

        // rx_en stays up through the accepting edge, drops one cycle later
        pulse_start();
        check("acc_busy", int'(busy), 1);
        check("acc_rx_en", int'(rx_en), 1);
        tick(1);
        check("acc_rx_en_drop", int'(rx_en), 0);
        rx = 1'b0;
        tick(27);
        rx = 1'b1;
        tick(27);
        en = 1'b0;
        tick(1);
        check("abort_busy", int'(busy), 0);
        check("abort_rx_en", int'(rx_en), 0);
        tick(20);
        check("abort_done", n_done, 0);
        check("abort_err", n_err, 0);
        check("abort_div", int'(baud_div), 434);
        en = 1'b1;
        tick(2);

        calibrate("t27", 27, 1, 0, 27);
        clear_counts();
        send_byte(8'hA3, 27);
        tick(4);
        check("a3_idle_events", n_done + n_err, 0);
        check("a3_div", int'(baud_div), 27);

        calibrate("t16", 16, 1, 0, 16);
        calibrate("t15", 15, 0, 1, 16);
        calibrate("t434", 434, 1, 0, 434);
        calibrate("t10", 10, 0, 1, 434);

        // Timeout: err_o in the cycle 1000 cycles after entering WAIT
        clear_counts();
        pulse_start();
        tick(999);
        check("tmo_err_early", int'(err), 0);
        check("tmo_busy_wait", int'(busy), 1);
        tick(1);
        check("tmo_err", int'(err), 1);
        check("tmo_busy", int'(busy), 0);
        tick(1);
        check("tmo_err_pulse", int'(err), 0);
        check("tmo_count", n_err, 1);
        check("tmo_div", int'(baud_div), 434);

        // 0x33 shows only three falling edges in its frame
        clear_counts();
        pulse_start();
        send_byte(8'h33, 434);
        tick(50);
        check("x33_done", n_done, 0);
`ifdef UART_AUTOBAUD_CHECK_EN
        check("x33_err", n_err, 1);
        check("x33_busy", int'(busy), 0);
`else
        check("x33_err", n_err, 0);
        check("x33_busy", int'(busy), 1);
`endif
        en = 1'b0;
        tick(2);
        check("x33_abort_busy", int'(busy), 0);
        check("x33_div", int'(baud_div), 434);
        en = 1'b1;
        tick(2);

        check("never_both", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
